ex_mem: RTL
===========

# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. It captures the execute-stage results and passes them to the memory stage on each clock edge: register write-back, HI/LO update, memory access operands, CP0 write and exception tag. It applies the shared stall/flush protocol: insert a bubble, hold, or advance. It also preserves the execute stage's two-cycle MADD/MSUB accumulation state across stalls.

## Interface
Parameters:
- none; all widths come from `defines.v`: AluOpBus 8, RegBus 32, RegAddrBus 5, DoubleRegBus 64.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (`RstEnable` = 1'b0), sampled on posedge clk.
- stall  in  6  pipeline stall vector; bit 3 = EX stage, bit 4 = MEM stage; `Stop` = 1.
- flush  in  1  exception flush; 1 = kill the in-flight instruction.
- ex_wd  in  5  destination GPR address.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  32  GPR write data.
- ex_hi, ex_lo  in  32 each  HI/LO write values.
- ex_whilo  in  1  HI/LO write enable.
- ex_aluop  in  8  ALU op, used by MEM for load/store decode.
- ex_mem_addr  in  32  effective load/store address.
- ex_reg2  in  32  store data.
- ex_cp0_reg_we  in  1  CP0 write enable.
- ex_cp0_reg_write_addr  in  5  CP0 register address.
- ex_cp0_reg_data  in  32  CP0 write data.
- ex_excepttype  in  32  exception flags.
- ex_is_in_delayslot  in  1  instruction is in a branch delay slot.
- ex_current_inst_address  in  32  PC of the instruction.
- hilo_i  in  64  partial MADD/MSUB product from EX.
- cnt_i  in  2  MADD/MSUB cycle counter from EX.
- mem_*  out  same widths  registered copies of every ex_* input above (mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2, mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_excepttype, mem_is_in_delayslot, mem_current_inst_address).
- hilo_o  out  64  accumulation state returned to EX.
- cnt_o  out  2  counter returned to EX.

## Operation
The branches below are evaluated each posedge in priority order.
- **Reset (rst == 0):**
  - All mem_* outputs go to zero: `ZeroWord`, `NOPRegAddr`, `WriteDisable`, `EXE_NOP_OP`, `NotInDelaySlot`.
  - hilo_o = 0, cnt_o = 0.
- **Flush (flush == 1):**
  - All mem_* outputs take their reset values (bubble).
  - hilo_o = 0, cnt_o = 0; flush abandons any partial MADD/MSUB.
- **Bubble (stall[3] == Stop && stall[4] == NoStop):**
  - All mem_* outputs take their reset values.
  - hilo_o <= hilo_i, cnt_o <= cnt_i; the EX stage is mid-MADD and needs its partial result next cycle.
- **Advance (stall[3] == NoStop):**
  - Every mem_* output <= its ex_* counterpart.
  - hilo_o = 0, cnt_o = 0.
- **Hold (otherwise, i.e. stall[3] && stall[4] both Stop):**
  - Every output, including hilo_o and cnt_o, keeps its value.
- **Boundary conditions:**
  - flush wins over any stall pattern.
  - An illegal stall pattern (bit 3 NoStop, bit 4 Stop) takes the Advance branch; upstream never generates it.
  - The block does no arithmetic; values pass through unmodified and bit-exact.

## Timing
- Latency is exactly one cycle, ex_* to mem_*; there is no combinational path from input to output.
- Reset, flush and bubble take effect at the edge where they are sampled.
- In the first cycle after rst deasserts, outputs still hold their reset values; the first capture happens at the next edge with rst == 1.
- hilo_o/cnt_o are valid for exactly the cycle after a bubble edge. EX consumes them during that cycle.

## Structure
- `defines.v` is extended with `DoubleRegBus` (63:0), `ZeroDoubleWord`, and `RstEnable` = 1'b0 / `RstDisable` = 1'b1.
- `defines.v` already provides `Stop`, `NoStop`, `NOPRegAddr`, `EXE_NOP_OP`, `WriteDisable` and `NotInDelaySlot`; the block reuses them.
- Single flat module, one always block. No sub-module is warranted.

## Test plan
- **Reset:**
  - Drive all ex_* inputs to 0xFFFFFFFF/ones and rst = 0 for 2 cycles.
  - Expect every output 0; mem_aluop = `EXE_NOP_OP`.
- **Advance:**
  - rst = 1, stall = 0, ex_wd = 5'd7, ex_wdata = 0x12345678, ex_wreg = 1, ex_mem_addr = 0x80000010.
  - Expect identical mem_* values one cycle later; hilo_o = 0.
- **MADD bubble:**
  - stall = 6'b001111 (bits 0–3 Stop, bit 4 NoStop), hilo_i = 0x00000001_FFFFFFFE, cnt_i = 2'b01.
  - Expect hilo_o = 0x00000001_FFFFFFFE, cnt_o = 1, mem_wreg = 0, mem_wd = 0.
  - On the next cycle, with stall = 0, expect hilo_o = 0, cnt_o = 0.
- **Hold:**
  - Load ex_wdata = 0xA5A5A5A5, then stall = 6'b011111 for 3 cycles while ex_wdata = 0x5A5A5A5A.
  - Expect mem_wdata to stay 0xA5A5A5A5 and hilo_o/cnt_o unchanged.
- **Flush priority:**
  - flush = 1 together with stall = 6'b011111 while mem_* holds valid data.
  - Expect all outputs 0 on the next cycle.
- **Reset mid-operation:**
  - During a bubble with cnt_o = 1, assert rst = 0 for 1 cycle.
  - Expect cnt_o = 0, hilo_o = 0 and all mem_* outputs at their reset values.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared widths, constants and the EX->MEM bundle type.
// Imported by the ex_mem pipeline register.
package ex_mem_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DREG_W     = 64;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;
  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
  localparam logic [DREG_W-1:0]     ZERO_DWORD   = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [ALU_OP_W-1:0]   EXE_NOP_OP   = 8'b0000_0000;
  localparam logic WRITE_DISABLE    = 1'b0;
  localparam logic NOT_IN_DSLOT     = 1'b0;

  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_W-1:0]      wdata;
    logic [REG_W-1:0]      hi;
    logic [REG_W-1:0]      lo;
    logic                  whilo;
    logic [ALU_OP_W-1:0]   aluop;
    logic [REG_W-1:0]      mem_addr;
    logic [REG_W-1:0]      reg2;
    logic                  cp0_we;
    logic [REG_ADDR_W-1:0] cp0_waddr;
    logic [REG_W-1:0]      cp0_data;
    logic [REG_W-1:0]      excepttype;
    logic                  in_dslot;
    logic [REG_W-1:0]      inst_addr;
  } ex_mem_t;

  localparam ex_mem_t MEM_BUBBLE = '{
    wd:         NOP_REG_ADDR,
    wreg:       WRITE_DISABLE,
    wdata:      ZERO_WORD,
    hi:         ZERO_WORD,
    lo:         ZERO_WORD,
    whilo:      WRITE_DISABLE,
    aluop:      EXE_NOP_OP,
    mem_addr:   ZERO_WORD,
    reg2:       ZERO_WORD,
    cp0_we:     WRITE_DISABLE,
    cp0_waddr:  NOP_REG_ADDR,
    cp0_data:   ZERO_WORD,
    excepttype: ZERO_WORD,
    in_dslot:   NOT_IN_DSLOT,
    inst_addr:  ZERO_WORD
  };

endpackage

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/flush handling.
// Also parks the MADD/MSUB partial product across EX stalls.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [REG_W-1:0]      ex_wdata,
  input  logic [REG_W-1:0]      ex_hi,
  input  logic [REG_W-1:0]      ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALU_OP_W-1:0]   ex_aluop,
  input  logic [REG_W-1:0]      ex_mem_addr,
  input  logic [REG_W-1:0]      ex_reg2,
  input  logic                  ex_cp0_reg_we,
  input  logic [REG_ADDR_W-1:0] ex_cp0_reg_write_addr,
  input  logic [REG_W-1:0]      ex_cp0_reg_data,
  input  logic [REG_W-1:0]      ex_excepttype,
  input  logic                  ex_is_in_delayslot,
  input  logic [REG_W-1:0]      ex_current_inst_address,
  input  logic [DREG_W-1:0]     hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [REG_W-1:0]      mem_wdata,
  output logic [REG_W-1:0]      mem_hi,
  output logic [REG_W-1:0]      mem_lo,
  output logic                  mem_whilo,
  output logic [ALU_OP_W-1:0]   mem_aluop,
  output logic [REG_W-1:0]      mem_mem_addr,
  output logic [REG_W-1:0]      mem_reg2,
  output logic                  mem_cp0_reg_we,
  output logic [REG_ADDR_W-1:0] mem_cp0_reg_write_addr,
  output logic [REG_W-1:0]      mem_cp0_reg_data,
  output logic [REG_W-1:0]      mem_excepttype,
  output logic                  mem_is_in_delayslot,
  output logic [REG_W-1:0]      mem_current_inst_address,
  output logic [DREG_W-1:0]     hilo_o,
  output logic [1:0]            cnt_o
);

  ex_mem_t ex_b;
  ex_mem_t mem_q;

  always_comb begin
    ex_b            = MEM_BUBBLE;
    ex_b.wd         = ex_wd;
    ex_b.wreg       = ex_wreg;
    ex_b.wdata      = ex_wdata;
    ex_b.hi         = ex_hi;
    ex_b.lo         = ex_lo;
    ex_b.whilo      = ex_whilo;
    ex_b.aluop      = ex_aluop;
    ex_b.mem_addr   = ex_mem_addr;
    ex_b.reg2       = ex_reg2;
    ex_b.cp0_we     = ex_cp0_reg_we;
    ex_b.cp0_waddr  = ex_cp0_reg_write_addr;
    ex_b.cp0_data   = ex_cp0_reg_data;
    ex_b.excepttype = ex_excepttype;
    ex_b.in_dslot   = ex_is_in_delayslot;
    ex_b.inst_addr  = ex_current_inst_address;
  end

  // Priority: reset, flush, bubble (EX stalled, MEM free), advance, hold.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mem_q  <= MEM_BUBBLE;
      hilo_o <= ZERO_DWORD;
      cnt_o  <= 2'b00;
    end else if (flush) begin
      mem_q  <= MEM_BUBBLE;
      hilo_o <= ZERO_DWORD;
      cnt_o  <= 2'b00;
    end else if (stall[ST_EX] == STOP &&
                 stall[ST_MEM] == NO_STOP) begin
      mem_q  <= MEM_BUBBLE;
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end else if (stall[ST_EX] == NO_STOP) begin
      mem_q  <= ex_b;
      hilo_o <= ZERO_DWORD;
      cnt_o  <= 2'b00;
    end
  end

  assign mem_wd                   = mem_q.wd;
  assign mem_wreg                 = mem_q.wreg;
  assign mem_wdata                = mem_q.wdata;
  assign mem_hi                   = mem_q.hi;
  assign mem_lo                   = mem_q.lo;
  assign mem_whilo                = mem_q.whilo;
  assign mem_aluop                = mem_q.aluop;
  assign mem_mem_addr             = mem_q.mem_addr;
  assign mem_reg2                 = mem_q.reg2;
  assign mem_cp0_reg_we           = mem_q.cp0_we;
  assign mem_cp0_reg_write_addr   = mem_q.cp0_waddr;
  assign mem_cp0_reg_data         = mem_q.cp0_data;
  assign mem_excepttype           = mem_q.excepttype;
  assign mem_is_in_delayslot      = mem_q.in_dslot;
  assign mem_current_inst_address = mem_q.inst_addr;

endmodule
